pixel_gen: RTL



---
 rtl/vga_pkg.sv | 14 +
 rtl/pixel_shifter.sv | 52 +++++
 rtl/pixel_gen.sv | 83 ++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared text-mode video constants: cell geometry, readout phase points, IRGB colour type.
package vga_pkg;
  localparam int CELL_W    = 8;
  localparam int FONT_ROWS = 16;
  localparam int ROW_W     = $clog2(FONT_ROWS);

  // Phase points of the 8-cycle cell counter, shared with the readout address generator
  localparam logic [2:0] PH_CHAR_SAMPLE = 3'd3;
  localparam logic [2:0] PH_ATTR_SAMPLE = 3'd7;
  localparam logic [2:0] PH_LOAD        = 3'd1;
  localparam logic [2:0] PH_START       = 3'd2;

  typedef logic [3:0] irgb_t;  // {I,R,G,B}
endpackage

// File: rtl/pixel_shifter.sv
// Per-cell glyph shift register plus IRGB colour mux; color/pixActive registered one cycle behind shiftReg.
// BLINK_EN: attribute bit 7 selects blink instead of background intensity.
module pixel_shifter
  import vga_pkg::*;
(
  input  logic              clk,
  input  logic              nrst,
  input  logic              load,
  input  logic              shiftEn,
  input  logic              pixOn,
  input  logic [CELL_W-1:0] fontData,
  input  logic [7:0]        attr,
  input  logic              blinkPhase,
  output irgb_t             color,
  output logic              pixActive
);
  logic [CELL_W-1:0] shiftReg;
  logic [7:0]        curAttr;
  irgb_t             fg, bg;

`ifdef BLINK_EN
  always_comb begin
    bg = {1'b0, curAttr[6:4]};
    fg = (curAttr[7] && blinkPhase) ? bg : curAttr[3:0];
  end
`else
  logic unusedBlink;
  assign unusedBlink = blinkPhase;
  always_comb begin
    bg = curAttr[7:4];
    fg = curAttr[3:0];
  end
`endif

  always_ff @(posedge clk) begin
    if (!nrst) begin
      shiftReg  <= '0;
      curAttr   <= '0;
      color     <= '0;
      pixActive <= 1'b0;
    end else begin
      if (load) begin
        shiftReg <= fontData;
        curAttr  <= attr;
      end else if (shiftEn) begin
        shiftReg <= shiftReg << 1;
      end
      color     <= pixOn ? (shiftReg[CELL_W-1] ? fg : bg) : irgb_t'(0);
      pixActive <= pixOn;
    end
  end
endmodule

// File: rtl/pixel_gen.sv
// Consumes VRAM char/attr bytes, looks up font rows and serialises 8 IRGB pixels per cell.
// Optional BLINK_EN: frame counter on vSync falling edges drives attribute blink.
module pixel_gen
  import vga_pkg::*;
#(
  parameter int BLINK_LOG2 = 5
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             vActive,
  input  logic             hBeginActive,
  input  logic             hEndActive,
  input  logic [ROW_W-1:0] vCount,
  input  logic             vSync,
  input  logic [7:0]       vramData,
  output logic [11:0]      fontAddr,
  input  logic [7:0]       fontData,
  output irgb_t            color,
  output logic             pixActive
);
  logic       active, pixOn;
  logic [2:0] count;
  logic [7:0] charReg, attrReg;
  logic       load, shiftEn, blinkPhase;

  assign load     = active && (count == PH_LOAD);
  assign shiftEn  = pixOn && !load;
  assign fontAddr = {charReg, vCount};

  always_ff @(posedge clk) begin
    if (!nrst) begin
      active  <= 1'b0;
      pixOn   <= 1'b0;
      count   <= '0;
      charReg <= '0;
      attrReg <= '0;
    end else begin
      if (hBeginActive && vActive && !active) begin
        active <= 1'b1;
        count  <= PH_START;
      end else begin
        if (active || pixOn) count <= count + 3'd1;
        if (hEndActive)      active <= 1'b0;
      end
      if (active && count == PH_CHAR_SAMPLE) charReg <= vramData;
      if (active && count == PH_ATTR_SAMPLE) attrReg <= vramData;
      // Without active at the load point the last cell has just drained
      if (count == PH_LOAD) pixOn <= active;
    end
  end

`ifdef BLINK_EN
  logic [BLINK_LOG2:0] frameCnt;
  logic                vSyncD;
  always_ff @(posedge clk) begin
    if (!nrst) begin
      frameCnt <= '0;
      vSyncD   <= 1'b1;
    end else begin
      vSyncD <= vSync;
      if (vSyncD && !vSync) frameCnt <= frameCnt + 1'b1;
    end
  end
  assign blinkPhase = frameCnt[BLINK_LOG2];
`else
  logic unusedBlink;
  assign blinkPhase  = 1'b0;
  assign unusedBlink = vSync ^ (BLINK_LOG2 > 0);
`endif

  pixel_shifter uShifter (
    .clk       (clk),
    .nrst      (nrst),
    .load      (load),
    .shiftEn   (shiftEn),
    .pixOn     (pixOn),
    .fontData  (fontData),
    .attr      (attrReg),
    .blinkPhase(blinkPhase),
    .color     (color),
    .pixActive (pixActive)
  );
endmodule
